dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_arbiter_if.sv | 42 ++++
 rtl/rr_arb2.sv | 14 +
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the two-port data-memory arbiter: default widths and
// FSM state encoding.
package dmem_pkg;

  localparam int NBITS_DEF    = 31;
  localparam int ADDRSZ_DEF   = 4;
  localparam int LOCK_MAX_DEF = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Client-side bundle of the arbiter: two request ports with grant and read
// response signals.
interface dmem_arbiter_if #(
  parameter int NBITS  = dmem_pkg::NBITS_DEF,
  parameter int ADDRSZ = dmem_pkg::ADDRSZ_DEF
);
  // Handshake: a client raises pN_req with we/lock/addr/wdata stable and holds
  // them until pN_gnt is seen high; the access happens at the posedge of that
  // gnt cycle. A read returns pN_rdata with a single-cycle pN_rvalid pulse in
  // the following cycle; pN_rdata holds until the next read.
  logic                     p0_req;
  logic                     p0_we;
  logic                     p0_lock;
  logic        [ADDRSZ:0]   p0_addr;
  logic signed [NBITS:0]    p0_wdata;
  logic                     p0_gnt;
  logic                     p0_rvalid;
  logic signed [NBITS:0]    p0_rdata;

  logic                     p1_req;
  logic                     p1_we;
  logic                     p1_lock;
  logic        [ADDRSZ:0]   p1_addr;
  logic signed [NBITS:0]    p1_wdata;
  logic                     p1_gnt;
  logic                     p1_rvalid;
  logic signed [NBITS:0]    p1_rdata;

  modport master (
    output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata
  );

  modport slave (
    input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selection; last_gnt names the port granted most
// recently, so the other port wins a tie.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt0,
  output logic gnt1
);

  assign gnt0 = req0 & (~req1 | last_gnt);
  assign gnt1 = req1 & (~req0 | ~last_gnt);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port memory with combinational read:
// round-robin grants, bounded lock ownership and registered read responses.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NBITS    = NBITS_DEF,
  parameter int ADDRSZ   = ADDRSZ_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  dmem_arbiter_if.slave          bus,
  output logic                   mem_write_ena,
  output logic        [ADDRSZ:0] mem_addr,
  output logic signed [NBITS:0]  mem_data_wr,
  input  logic signed [NBITS:0]  mem_data_rd,
  output state_t                 dbg_state
);

  localparam int CW       = $clog2(LOCK_MAX + 1);
  localparam bit CAN_LOCK = (LOCK_MAX > 1);

  state_t        state, state_nxt;
  logic          last_gnt, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          req0_m, req1_m, gnt0, gnt1;

  // A locked owner masks the other port out of arbitration; reset masks both.
  assign req0_m = bus.p0_req & ~rst & (state != ST_LOCK1);
  assign req1_m = bus.p1_req & ~rst & (state != ST_LOCK0);

  rr_arb2 u_rr (
    .req0     (req0_m),
    .req1     (req1_m),
    .last_gnt (last_gnt),
    .gnt0     (gnt0),
    .gnt1     (gnt1)
  );

  assign bus.p0_gnt = gnt0;
  assign bus.p1_gnt = gnt1;
  assign dbg_state  = state;
  assign cnt_inc    = cnt + CW'(1);

  always_comb begin
    mem_write_ena = 1'b0;
    mem_addr      = '0;
    mem_data_wr   = '0;
    if (gnt0) begin
      mem_write_ena = bus.p0_we;
      mem_addr      = bus.p0_addr;
      mem_data_wr   = bus.p0_wdata;
    end else if (gnt1) begin
      mem_write_ena = bus.p1_we;
      mem_addr      = bus.p1_addr;
      mem_data_wr   = bus.p1_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last_gnt;
    if (gnt0) last_nxt = 1'b0;
    if (gnt1) last_nxt = 1'b1;
    case (state)
      ST_ARB: begin
        if (CAN_LOCK && ((gnt0 && bus.p0_lock) || (gnt1 && bus.p1_lock))) begin
          state_nxt = gnt1 ? ST_LOCK1 : ST_LOCK0;
          cnt_nxt   = CW'(1);
        end
      end
      ST_LOCK0: begin
        // Stay only while the owner keeps locking and has budget left.
        if (gnt0 && bus.p0_lock && (cnt_inc != CW'(LOCK_MAX))) begin
          cnt_nxt = cnt_inc;
        end else begin
          state_nxt = ST_ARB;
          cnt_nxt   = '0;
        end
      end
      ST_LOCK1: begin
        if (gnt1 && bus.p1_lock && (cnt_inc != CW'(LOCK_MAX))) begin
          cnt_nxt = cnt_inc;
        end else begin
          state_nxt = ST_ARB;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_ARB;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_ARB;
      last_gnt      <= 1'b1;
      cnt           <= '0;
      bus.p0_rvalid <= 1'b0;
      bus.p1_rvalid <= 1'b0;
      bus.p0_rdata  <= '0;
      bus.p1_rdata  <= '0;
    end else begin
      state         <= state_nxt;
      last_gnt      <= last_nxt;
      cnt           <= cnt_nxt;
      bus.p0_rvalid <= gnt0 & ~bus.p0_we;
      bus.p1_rvalid <= gnt1 & ~bus.p1_we;
      if (gnt0 && !bus.p0_we) bus.p0_rdata <= mem_data_rd;
      if (gnt1 && !bus.p1_we) bus.p1_rdata <= mem_data_rd;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an ownership/queue model.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int LOCK_MAX = 8;

  logic               clk;
  logic               rst;
  logic               mem_write_ena;
  logic [4:0]         mem_addr;
  logic signed [31:0] mem_data_wr;
  logic signed [31:0] mem_data_rd;
  logic [1:0]         dbg_state;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.NBITS(31), .ADDRSZ(4), .LOCK_MAX(LOCK_MAX)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .mem_write_ena (mem_write_ena),
    .mem_addr      (mem_addr),
    .mem_data_wr   (mem_data_wr),
    .mem_data_rd   (mem_data_rd),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / memory environment ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [31:0] mem [32];
  assign mem_data_rd = mem[mem_addr];
  always @(posedge clk) if (mem_write_ena) mem[mem_addr] <= mem_data_wr;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [31:0] ref_mem [32];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] hold0, hold1;
  int owner  = -1;
  int streak = 0;
  int last   = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic req_of(int p);  return p ? bus.p1_req  : bus.p0_req;  endfunction
  function automatic logic we_of(int p);   return p ? bus.p1_we   : bus.p0_we;   endfunction
  function automatic logic lock_of(int p); return p ? bus.p1_lock : bus.p0_lock; endfunction
  function automatic logic [4:0] addr_of(int p);   return p ? bus.p1_addr  : bus.p0_addr;  endfunction
  function automatic logic [31:0] wdata_of(int p); return p ? bus.p1_wdata : bus.p0_wdata; endfunction

  // Who must be granted this cycle: the lock owner exclusively, otherwise the
  // lone requester, otherwise whichever port did not win last time.
  function automatic int model_grant();
    if (rst) return -1;
    if (owner >= 0) return req_of(owner) ? owner : -1;
    if (bus.p0_req && bus.p1_req) return 1 - last;
    if (bus.p0_req) return 0;
    if (bus.p1_req) return 1;
    return -1;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp_proc
    int g;
    logic ev0, ev1;
    ev0 = (exp_q0.size() > 0);
    ev1 = (exp_q1.size() > 0);
    if (ev0) hold0 = exp_q0.pop_front();
    if (ev1) hold1 = exp_q1.pop_front();
    g = model_grant();
    if (chk_en) begin
      chk("p0_rvalid", {31'b0, bus.p0_rvalid}, {31'b0, ev0});
      chk("p1_rvalid", {31'b0, bus.p1_rvalid}, {31'b0, ev1});
      chk("p0_rdata", bus.p0_rdata, hold0);
      chk("p1_rdata", bus.p1_rdata, hold1);
      chk("p0_gnt", {31'b0, bus.p0_gnt}, {31'b0, g == 0});
      chk("p1_gnt", {31'b0, bus.p1_gnt}, {31'b0, g == 1});
      chk("gnt_exclusive", {31'b0, bus.p0_gnt & bus.p1_gnt}, 32'd0);
      chk("mem_write_ena", {31'b0, mem_write_ena}, {31'b0, (g >= 0) && we_of(g)});
      chk("mem_addr", {27'b0, mem_addr}, (g >= 0) ? {27'b0, addr_of(g)} : 32'd0);
      chk("mem_data_wr", mem_data_wr, (g >= 0) ? wdata_of(g) : 32'd0);
    end
    if (rst) begin
      owner = -1; streak = 0; last = 1;
      exp_q0.delete(); exp_q1.delete();
      hold0 = '0; hold1 = '0;
    end else begin
      if (g >= 0) begin
        if (we_of(g)) ref_mem[addr_of(g)] = wdata_of(g);
        else if (g == 0) exp_q0.push_back(ref_mem[addr_of(0)]);
        else exp_q1.push_back(ref_mem[addr_of(1)]);
        last = g;
      end
      if (owner >= 0) begin
        if (g == owner && lock_of(owner) && streak + 1 < LOCK_MAX) streak++;
        else begin owner = -1; streak = 0; end
      end else if (g >= 0 && lock_of(g) && LOCK_MAX > 1) begin
        owner = g; streak = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(input logic r, w, l, input logic [4:0] a, input logic [31:0] d);
    bus.p0_req = r; bus.p0_we = w; bus.p0_lock = l; bus.p0_addr = a; bus.p0_wdata = d;
  endtask

  task automatic set_p1(input logic r, w, l, input logic [4:0] a, input logic [31:0] d);
    bus.p1_req = r; bus.p1_we = w; bus.p1_lock = l; bus.p1_addr = a; bus.p1_wdata = d;
  endtask

  task automatic idle();
    set_p0(0, 0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt, first_p1, lock_bias;
    logic g0, g1, hold_p0, hold_p1;

    for (int i = 0; i < 32; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    hold0 = '0; hold1 = '0;
    rst = 1'b1;
    idle();

    // Reset: no grant, no write strobe while rst is high.
    @(negedge clk);
    chk("rst_gnt0", {31'b0, bus.p0_gnt}, 32'd0);
    chk("rst_gnt1", {31'b0, bus.p1_gnt}, 32'd0);
    chk("rst_we", {31'b0, mem_write_ena}, 32'd0);
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, ST_ARB});
    chk("rst_rdata0", bus.p0_rdata, 32'd0);
    chk("rst_rvalid1", {31'b0, bus.p1_rvalid}, 32'd0);
    tick();
    rst = 1'b0;

    // Write then read-back through the other port.
    set_p0(1, 1, 0, 5'd3, 32'h1234_5678);
    @(negedge clk);
    chk("wr_gnt0", {31'b0, bus.p0_gnt}, 32'd1);
    chk("wr_addr", {27'b0, mem_addr}, 32'd3);
    chk("wr_data", mem_data_wr, 32'h1234_5678);
    tick();
    set_p0(0, 0, 0, 0, 0);
    set_p1(1, 0, 0, 5'd3, 0);
    @(negedge clk);
    chk("raw_gnt1", {31'b0, bus.p1_gnt}, 32'd1);
    tick();
    set_p1(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("raw_rvalid1", {31'b0, bus.p1_rvalid}, 32'd1);
    chk("raw_rdata1", bus.p1_rdata, 32'h1234_5678);
    tick();

    // Continuous contention alternates p0, p1, ...
    do_reset();
    set_p0(1, 0, 0, 5'd1, 0);
    set_p1(1, 0, 0, 5'd2, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("alt_gnt0", {31'b0, bus.p0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_gnt1", {31'b0, bus.p1_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
    end

    // p0 locked for four reads holds p1 off; p1 wins right after.
    do_reset();
    set_p1(1, 0, 0, 5'd5, 0);
    for (int i = 0; i < 4; i++) begin
      set_p0(1, 0, (i < 3), 5'(i), 0);
      @(negedge clk);
      chk("lock_p0", {31'b0, bus.p0_gnt}, 32'd1);
      chk("lock_p1_held", {31'b0, bus.p1_gnt}, 32'd0);
      tick();
    end
    set_p0(1, 0, 0, 5'd0, 0);
    @(negedge clk);
    chk("unlock_p1", {31'b0, bus.p1_gnt}, 32'd1);
    tick();

    // Lock held indefinitely is cut after LOCK_MAX grants.
    do_reset();
    set_p1(1, 0, 0, 5'd6, 0);
    set_p0(1, 0, 1, 5'd7, 0);
    cnt = 0;
    first_p1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (first_p1 < 0) begin
        if (bus.p1_gnt) first_p1 = i;
        else if (bus.p0_gnt) cnt++;
      end
      tick();
    end
    chk("lockmax_p0_grants", cnt, 32'd8);
    chk("lockmax_p1_slot", first_p1, 32'd8);

    // Reset while p1 owns the lock and is writing.
    do_reset();
    set_p1(1, 1, 1, 5'd9, 32'hA5A5_0001);
    @(negedge clk);
    chk("l1_enter", {31'b0, bus.p1_gnt}, 32'd1);
    tick();
    set_p1(1, 0, 1, 5'd3, 0);
    @(negedge clk);
    chk("l1_state", {30'b0, dbg_state}, {30'b0, ST_LOCK1});
    tick();
    set_p1(1, 1, 1, 5'd10, 32'h0BAD_F00D);
    @(negedge clk);
    chk("l1_rdata", bus.p1_rdata, 32'h1234_5678);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstlock_we", {31'b0, mem_write_ena}, 32'd0);
    chk("rstlock_gnt1", {31'b0, bus.p1_gnt}, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("rstlock_state", {30'b0, dbg_state}, {30'b0, ST_ARB});
    chk("rstlock_rvalid1", {31'b0, bus.p1_rvalid}, 32'd0);
    chk("rstlock_rdata1", bus.p1_rdata, 32'd0);
    chk("rstlock_mem10", mem[10], ref_mem[10]);
    tick();

    // Idle bus is quiet.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_we", {31'b0, mem_write_ena}, 32'd0);
      chk("idle_addr", {27'b0, mem_addr}, 32'd0);
      chk("idle_wdata", mem_data_wr, 32'd0);
      chk("idle_rvalid", {30'b0, bus.p1_rvalid, bus.p0_rvalid}, 32'd0);
      tick();
    end

    // Randomized traffic; requests stay stable until granted.
    hold_p0 = 1'b0;
    hold_p1 = 1'b0;
    lock_bias = 2;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) lock_bias = $urandom_range(0, 8);
      if (!hold_p0)
        set_p0($urandom_range(0, 3) != 0, $urandom_range(0, 1),
               $urandom_range(0, 7) < lock_bias, 5'($urandom_range(0, 7)), $urandom);
      if (!hold_p1)
        set_p1($urandom_range(0, 3) != 0, $urandom_range(0, 1),
               $urandom_range(0, 7) < lock_bias, 5'($urandom_range(0, 7)), $urandom);
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      g0 = bus.p0_gnt;
      g1 = bus.p1_gnt;
      tick();
      hold_p0 = bus.p0_req && !g0 && !rst;
      hold_p1 = bus.p1_req && !g1 && !rst;
    end
    rst = 1'b0;
    idle();
    tick();

    for (int i = 0; i < 32; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
